// File: rtl/dmem_lsu_if.sv
// Request/response bus between the core and the load/store unit.
// The core drives the master modport and the LSU implements the slave modport.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit with an internal word-organised data memory.
// Handles RV32I byte, halfword and word accesses, including sign and zero extension.
// A valid/ready request is followed by a single-cycle response after WAIT wait states.
// Define LSU_MISALIGN_CHECK_EN to report misaligned H/W accesses as errors.
// When it is undefined, the offending low address bits are cleared instead.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | req_ready high; the next request is latched on accept
// WAITST | wait-state countdown, running while the memory is busy
// RESP   | rsp_valid high; load data is read, store commits at the edge
module dmem_lsu #(
  parameter int DEPTH = 256,
  parameter int WAIT  = 1
) (
  input logic      clk,
  input logic      reset,
  dmem_lsu_if.slave bus
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LAW = AW + 2;
  // Terminal count for the down-counter. The counter is not used when WAIT is 0.
  localparam logic [3:0] WAIT_TC = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAITST = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q;
  logic [2:0]       funct3_q;
  logic [LAW-1:0]   addr_q;
  logic [31:0]      wdata_q;

  logic [31:0]      mem [DEPTH];

  logic             accept;
  logic             f3_illegal;
  logic             misalign;
  logic             acc_err;
  logic [LAW-1:0]   eff_addr;
  logic [AW-1:0]    idx;
  logic [1:0]       lane;
  logic [31:0]      rd_word;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      ld_data;
  logic [3:0]       be;
  logic [31:0]      st_data;

  assign accept = bus.req_valid && (state_q == S_IDLE);

  // State register and wait-state down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request on accept. The inputs are ignored at all other times.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
    end else if (accept) begin
      we_q     <= bus.req_we;
      funct3_q <= bus.req_funct3;
      addr_q   <= bus.req_addr[LAW-1:0];
      wdata_q  <= bus.req_wdata;
    end
  end

  // Next-state logic: IDLE -> (WAITST ->) RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT > 0) begin
            state_d = S_WAITST;
            cnt_d   = WAIT_TC;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAITST: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Decode the latched access: legal funct3, alignment and effective address.
  always_comb begin
    f3_illegal = 1'b0;
    misalign   = 1'b0;
    eff_addr   = addr_q;
    if (we_q) begin
      f3_illegal = funct3_q[2] || (funct3_q[1:0] == 2'b11);
    end else begin
      f3_illegal = (funct3_q == 3'b011) || (funct3_q == 3'b110) || (funct3_q == 3'b111);
    end
    unique case (funct3_q[1:0])
      2'b01: begin
        misalign    = addr_q[0];
        eff_addr[0] = 1'b0;
      end
      2'b10: begin
        misalign      = |addr_q[1:0];
        eff_addr[1:0] = 2'b00;
      end
      default: begin
        misalign = 1'b0;
      end
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign acc_err = f3_illegal || misalign;
`else
  assign acc_err = f3_illegal;
`endif

  assign idx  = eff_addr[LAW-1:2];
  assign lane = eff_addr[1:0];

  // Load path: read the word, pick the lane and extend it.
  always_comb begin
    rd_word = mem[idx];
    rd_byte = 8'd0;
    rd_half = 16'd0;
    ld_data = 32'd0;
    unique case (lane)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    unique case (funct3_q)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'd0, rd_byte};
      3'b101:  ld_data = {16'd0, rd_half};
      default: ld_data = 32'd0;
    endcase
  end

  // Store path: byte enables and lane-replicated write data.
  always_comb begin
    be      = 4'b0000;
    st_data = wdata_q;
    unique case (funct3_q[1:0])
      2'b00: begin
        be      = 4'b0001 << lane;
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be      = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        be = 4'b1111;
      end
      default: begin
        be = 4'b0000;
      end
    endcase
  end

  // Commit stores on the edge that ends RESP. Reset forces IDLE, so a pending store is dropped.
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && we_q && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= st_data[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_err   = (state_q == S_RESP) && acc_err;
  assign bus.rsp_rdata = (state_q == S_RESP && !we_q && !acc_err) ? ld_data : 32'd0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed testbench for dmem_lsu: a table of accesses with hand-computed results,
// followed by handshake, busy-ignore and reset-mid-access sequences.
module tb_dmem_lsu;

  localparam int TB_DEPTH = 256;
  localparam int TB_WAIT  = 1;
  localparam int BUDGET   = 40;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  dmem_lsu_if bus_if ();

  dmem_lsu #(.DEPTH(TB_DEPTH), .WAIT(TB_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One complete access, starting and ending on a falling edge with the DUT idle.
  task automatic do_access(input vec_t v);
    int n;
    bus_if.req_we     = v.we;
    bus_if.req_funct3 = v.f3;
    bus_if.req_addr   = v.addr;
    bus_if.req_wdata  = v.wdata;
    bus_if.req_valid  = 1'b1;
    n = 0;
    while (!bus_if.req_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk({v.name, " ready"}, 32'(bus_if.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    n = 1;
    while (!bus_if.rsp_valid && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk({v.name, " latency"}, 32'(n - 1), 32'(TB_WAIT));
    chk({v.name, " rdata"}, bus_if.rsp_rdata, v.exp_rdata);
    chk({v.name, " err"}, 32'(bus_if.rsp_err), 32'(v.exp_err));
    @(negedge clk);
    chk({v.name, " pulse"}, 32'(bus_if.rsp_valid), 32'd0);
  endtask

  function automatic vec_t mk(input string name, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  initial begin
    int        acc_cyc[$];
    int        rsp_cnt;
    int        seen;
    logic      chk_en;
`ifdef LSU_MISALIGN_CHECK_EN
    chk_en = 1'b1;
`else
    chk_en = 1'b0;
`endif
    checks = 0;
    errors = 0;

    vecs.push_back(mk("sw10",      1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0, 0));
    vecs.push_back(mk("lw10",      0, 3'b010, 32'h10,  32'h0, 32'hDEADBEEF, 0));
    vecs.push_back(mk("sb13",      1, 3'b000, 32'h13,  32'h00000080, 32'h0, 0));
    vecs.push_back(mk("lb13",      0, 3'b000, 32'h13,  32'h0, 32'hFFFFFF80, 0));
    vecs.push_back(mk("lbu13",     0, 3'b100, 32'h13,  32'h0, 32'h00000080, 0));
    vecs.push_back(mk("lw10b",     0, 3'b010, 32'h10,  32'h0, 32'h80ADBEEF, 0));
    vecs.push_back(mk("sh12",      1, 3'b001, 32'h12,  32'h00008001, 32'h0, 0));
    vecs.push_back(mk("lh12",      0, 3'b001, 32'h12,  32'h0, 32'hFFFF8001, 0));
    vecs.push_back(mk("lhu12",     0, 3'b101, 32'h12,  32'h0, 32'h00008001, 0));
    vecs.push_back(mk("lw11",      0, 3'b010, 32'h11,  32'h0,
                      chk_en ? 32'h0 : 32'h8001BEEF, chk_en));
    vecs.push_back(mk("ld_f3_011", 0, 3'b011, 32'h10,  32'h0, 32'h0, 1));
    vecs.push_back(mk("ld_f3_110", 0, 3'b110, 32'h10,  32'h0, 32'h0, 1));
    vecs.push_back(mk("st_f3_100", 1, 3'b100, 32'h10,  32'h0, 32'h0, 1));
    vecs.push_back(mk("st_f3_011", 1, 3'b011, 32'h10,  32'h0, 32'h0, 1));
    vecs.push_back(mk("lw10c",     0, 3'b010, 32'h10,  32'h0, 32'h8001BEEF, 0));
    vecs.push_back(mk("sw410",     1, 3'b010, 32'h410, 32'h12345678, 32'h0, 0));
    vecs.push_back(mk("lw10wrap",  0, 3'b010, 32'h10,  32'h0, 32'h12345678, 0));
    vecs.push_back(mk("sb11",      1, 3'b000, 32'h11,  32'hFFFFFFA5, 32'h0, 0));
    vecs.push_back(mk("lb11",      0, 3'b000, 32'h11,  32'h0, 32'hFFFFFFA5, 0));
    vecs.push_back(mk("lb10",      0, 3'b000, 32'h10,  32'h0, 32'h00000078, 0));
    vecs.push_back(mk("lw10d",     0, 3'b010, 32'h10,  32'h0, 32'h1234A578, 0));
    vecs.push_back(mk("sw14",      1, 3'b010, 32'h14,  32'h00000000, 32'h0, 0));
    vecs.push_back(mk("sh15",      1, 3'b001, 32'h15,  32'h1234BEEF, 32'h0, chk_en));
    vecs.push_back(mk("lw14",      0, 3'b010, 32'h14,  32'h0,
                      chk_en ? 32'h0 : 32'h0000BEEF, 0));
    vecs.push_back(mk("lhu16",     0, 3'b101, 32'h16,  32'h0, 32'h0, 0));

    bus_if.req_valid  = 1'b0;
    bus_if.req_we     = 1'b0;
    bus_if.req_funct3 = 3'b010;
    bus_if.req_addr   = 32'h0;
    bus_if.req_wdata  = 32'h0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst ready", 32'(bus_if.req_ready), 32'd1);
    chk("rst valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("rst rdata", bus_if.rsp_rdata, 32'd0);
    chk("rst err",   32'(bus_if.rsp_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) do_access(vecs[i]);

    // req_valid held high: accepts every 2+WAIT cycles, one response per accept.
    bus_if.req_we     = 1'b0;
    bus_if.req_funct3 = 3'b010;
    bus_if.req_addr   = 32'h10;
    bus_if.req_valid  = 1'b1;
    rsp_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus_if.req_ready) acc_cyc.push_back(c);
      if (bus_if.rsp_valid) begin
        rsp_cnt++;
        chk("hold rdata", bus_if.rsp_rdata, 32'h1234A578);
      end
      @(negedge clk);
    end
    bus_if.req_valid = 1'b0;
    chk("hold accepts", 32'(acc_cyc.size()), 32'd4);
    chk("hold responses", 32'(rsp_cnt), 32'd3);
    for (int k = 1; k < acc_cyc.size(); k++)
      chk("hold spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'(2 + TB_WAIT));
    repeat (3) @(negedge clk);

    // A store presented while busy is ignored.
    bus_if.req_we = 1'b0; bus_if.req_funct3 = 3'b010; bus_if.req_addr = 32'h10;
    bus_if.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.req_we = 1'b1; bus_if.req_wdata = 32'h0BADF00D;
    seen = 0;
    for (int c = 0; c < BUDGET && seen == 0; c++) begin
      if (bus_if.rsp_valid) begin
        seen = 1;
        chk("busy rdata", bus_if.rsp_rdata, 32'h1234A578);
        bus_if.req_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    chk("busy rsp seen", 32'(seen), 32'd1);
    bus_if.req_valid = 1'b0;
    @(negedge clk);
    do_access(mk("busy_lw", 0, 3'b010, 32'h10, 32'h0, 32'h1234A578, 0));

    // Reset during the wait state drops the pending store.
    bus_if.req_we = 1'b1; bus_if.req_funct3 = 3'b010; bus_if.req_addr = 32'h10;
    bus_if.req_wdata = 32'hFFFFFFFF; bus_if.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst ready", 32'(bus_if.req_ready), 32'd1);
    chk("midrst valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("midrst rdata", bus_if.rsp_rdata, 32'd0);
    chk("midrst err",   32'(bus_if.rsp_err), 32'd0);
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus_if.rsp_valid) seen++;
    end
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus_if.rsp_valid) seen++;
    end
    chk("midrst no rsp", 32'(seen), 32'd0);
    do_access(mk("midrst_lw", 0, 3'b010, 32'h10, 32'h0, 32'h1234A578, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
